// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory access controller: FSM states,
// access-size masks and the alignment rule.
package mem_access_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam logic [1:0] MASK_BYTE = 2'b00;
    localparam logic [1:0] MASK_HALF = 2'b01;
    localparam logic [1:0] MASK_WORD = 2'b10;

    // Halves need an even address; words (mask 2'b1x) need a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] mask, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (mask[1])
            bad = (addr_lo != 2'b00);
        else if (mask == MASK_HALF)
            bad = addr_lo[0];
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_store_lane_align.sv
// Replicates right-justified store data across byte lanes and builds the
// little-endian byte enables for the addressed lanes.
module store_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  mask,
    output logic [31:0] lane_wdata,
    output logic [3:0]  lane_be
);

    always_comb begin
        lane_wdata = wdata;
        lane_be    = 4'b1111;
        if (mask == MASK_BYTE) begin
            lane_wdata = {4{wdata[7:0]}};
            lane_be    = 4'b0001 << addr_lo;
        end else if (mask == MASK_HALF) begin
            lane_wdata = {2{wdata[15:0]}};
            lane_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller driving a word-wide RAM over req/ack, with alignment
// and timeout error reporting; load results are registered for RamLoadProc.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  mask,
    input  logic        signed_ext,
    output logic        busy,
    output logic        done,
    output logic        align_err,
    output logic        bus_err,
    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_be,
    input  logic        ram_ack,
    input  logic [31:0] ram_rdata,
    output logic [31:0] ld_word,
    output logic [1:0]  ld_addr,
    output logic [1:0]  ld_mask,
    output logic        ld_signed
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]       state_q;
    logic             err_bus_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       addr_lo_q;
    logic [1:0]       mask_q;
    logic             sext_q;
    logic [31:0]      lane_wdata;
    logic [3:0]       lane_be;

    store_lane_align u_lane (
        .wdata      (wdata),
        .addr_lo    (addr[1:0]),
        .mask       (mask),
        .lane_wdata (lane_wdata),
        .lane_be    (lane_be)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            err_bus_q <= 1'b0;
            cnt_q     <= '0;
            addr_lo_q <= 2'b00;
            mask_q    <= 2'b00;
            sext_q    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_be    <= 4'b0000;
            ld_word   <= '0;
            ld_addr   <= 2'b00;
            ld_mask   <= 2'b00;
            ld_signed <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (is_misaligned(mask, addr[1:0])) begin
                            state_q   <= ST_ERR;
                            err_bus_q <= 1'b0;
                        end else begin
                            state_q   <= ST_REQ;
                            cnt_q     <= '0;
                            ram_we    <= we;
                            ram_addr  <= {addr[31:2], 2'b00};
                            ram_wdata <= we ? lane_wdata : 32'h0;
                            ram_be    <= we ? lane_be : 4'b1111;
                            addr_lo_q <= addr[1:0];
                            mask_q    <= mask;
                            sext_q    <= signed_ext;
                        end
                    end
                end
                ST_REQ: begin
                    // Ack on the final allowed cycle still counts as success.
                    if (ram_ack) begin
                        state_q <= ST_DONE;
                        if (!ram_we) begin
                            ld_word   <= ram_rdata;
                            ld_addr   <= addr_lo_q;
                            ld_mask   <= mask_q;
                            ld_signed <= sext_q;
                        end
                    end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                        state_q   <= ST_ERR;
                        err_bus_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Status and request strobes decode straight from the state flop so reset clears them at once.
    assign busy      = (state_q != ST_IDLE);
    assign ram_req   = (state_q == ST_REQ);
    assign done      = (state_q == ST_DONE);
    assign align_err = (state_q == ST_ERR) && !err_bus_q;
    assign bus_err   = (state_q == ST_ERR) && err_bus_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomised bench for mem_access_ctrl against a transaction-level model of
// lane placement, alignment, handshake length and load-result holding.
module tb_mem_access_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  mask = '0;
    logic        signed_ext = 1'b0;
    logic        busy, done, align_err, bus_err;
    logic        ram_req, ram_we;
    logic [31:0] ram_addr, ram_wdata;
    logic [3:0]  ram_be;
    logic        ram_ack = 1'b0;
    logic [31:0] ram_rdata = '0;
    logic [31:0] ld_word;
    logic [1:0]  ld_addr, ld_mask;
    logic        ld_signed;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_ld_word = '0;
    logic [1:0]  m_ld_addr = '0;
    logic [1:0]  m_ld_mask = '0;
    logic        m_ld_sgn  = 1'b0;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .we(we), .addr(addr),
        .wdata(wdata), .mask(mask), .signed_ext(signed_ext), .busy(busy),
        .done(done), .align_err(align_err), .bus_err(bus_err),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_ack(ram_ack),
        .ram_rdata(ram_rdata), .ld_word(ld_word), .ld_addr(ld_addr),
        .ld_mask(ld_mask), .ld_signed(ld_signed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ld();
        chk("ld_word", ld_word, m_ld_word);
        chk("ld_addr", 32'(ld_addr), 32'(m_ld_addr));
        chk("ld_mask", 32'(ld_mask), 32'(m_ld_mask));
        chk("ld_signed", 32'(ld_signed), 32'(m_ld_sgn));
    endtask

    // One transaction from IDLE; dly = wait cycles before ack (>= TO means never).
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] m, input logic s, input int dly,
                       input logic [31:0] rd, input bit poke);
        int size, off, nreq;
        bit mis, ok;
        logic [31:0] ew;
        logic [3:0]  eb;
        size = (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
        mis  = (a % size) != 0;
        off  = ((a % 4) / size) * size;
        ew = '0;
        eb = '0;
        if (!w) begin
            eb = 4'hF;
        end else begin
            for (int i = 0; i < 4; i++) ew[8*i +: 8] = d[8*(i % size) +: 8];
            for (int i = 0; i < size; i++) eb[off + i] = 1'b1;
        end
        ok   = (dly < TO);
        nreq = ok ? dly + 1 : TO;

        start = 1'b1; we = w; addr = a; wdata = d; mask = m; signed_ext = s;
        @(negedge clk);
        start = 1'b0; addr = $urandom; wdata = $urandom; we = $urandom_range(0, 1);
        if (mis) begin
            chk("align_err", 32'(align_err), 32'd1);
            chk("align_busy", 32'(busy), 32'd1);
            chk("align_noreq", 32'(ram_req), 32'd0);
            @(negedge clk);
            chk("align_end", 32'(align_err), 32'd0);
            chk("align_idle", 32'(busy), 32'd0);
            chk_ld();
            return;
        end
        for (int k = 0; k < nreq; k++) begin
            chk("ram_req", 32'(ram_req), 32'd1);
            chk("req_done", 32'(done), 32'd0);
            chk("ram_addr", ram_addr, a & 32'hFFFF_FFFC);
            chk("ram_we", 32'(ram_we), 32'(w));
            chk("ram_be", 32'(ram_be), 32'(eb));
            chk("ram_wdata", ram_wdata, ew);
            ram_ack = (k == dly);
            ram_rdata = (k == dly) ? rd : $urandom;
            if (poke) start = $urandom_range(0, 1);
            @(negedge clk);
            ram_ack = 1'b0;
            start = 1'b0;
        end
        chk("end_req", 32'(ram_req), 32'd0);
        chk("end_busy", 32'(busy), 32'd1);
        chk("done", 32'(done), 32'(ok));
        chk("bus_err", 32'(bus_err), 32'(!ok));
        if (ok && !w) begin
            m_ld_word = rd;
            m_ld_addr = a[1:0];
            m_ld_mask = m;
            m_ld_sgn  = s;
        end
        chk_ld();
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_berr", 32'(bus_err), 32'd0);
        chk("idle_req", 32'(ram_req), 32'd0);
    endtask

    initial begin
        int dly;
        logic [1:0] m;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(ram_req), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_addr", ram_addr, 32'd0);
        chk("rst_wdata", ram_wdata, 32'd0);
        chk("rst_be", 32'(ram_be), 32'd0);
        chk("rst_flags", {29'd0, done, align_err, bus_err}, 32'd0);
        chk_ld();
        rst_n = 1'b1;
        @(negedge clk);

        txn(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 0, 32'hDEADBEEF, 1'b0);
        txn(1'b1, 32'h203, 32'hA5, 2'b00, 1'b0, 0, 32'h0, 1'b0);
        txn(1'b1, 32'h002, 32'h1234, 2'b01, 1'b0, 3, 32'h0, 1'b0);
        txn(1'b0, 32'h001, 32'h0, 2'b01, 1'b1, 0, 32'h0, 1'b0);
        txn(1'b0, 32'h006, 32'h0, 2'b10, 1'b0, 0, 32'h0, 1'b0);
        txn(1'b0, 32'h040, 32'h0, 2'b10, 1'b0, 1000, 32'h0, 1'b1);
        txn(1'b0, 32'h302, 32'h0, 2'b01, 1'b1, TO - 1, 32'h8000_F00D, 1'b1);

        // Reset while a load sits in REQ.
        start = 1'b1; we = 1'b0; addr = 32'h500; mask = 2'b10;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(ram_req), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        m_ld_word = '0; m_ld_addr = '0; m_ld_mask = '0; m_ld_sgn = 1'b0;
        chk_ld();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_nodone", 32'(done), 32'd0);
        txn(1'b0, 32'h104, 32'h0, 2'b10, 1'b0, 1, 32'hCAFE_1234, 1'b0);

        for (int i = 0; i < 300; i++) begin
            m = 2'($urandom_range(0, 3));
            dly = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 2, TO + 4))
                                               : int'($urandom_range(0, 4));
            txn(1'($urandom_range(0, 1)), $urandom, $urandom, m, 1'($urandom_range(0, 1)),
                dly, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle data-memory access controller sitting directly upstream of `RamLoadProc`. Accepts one load/store request per transaction from the CPU MEM state and drives a word-wide RAM port with a req/ack handshake. Aligns store data onto byte lanes and detects misaligned accesses. Registers the returned read word plus its address/mask/sign controls so they feed `RamLoadProc` unchanged (`ld_*` → `ram_data_in`/`addr`/`mask`/`signed_ext`).

## Interface
- `TIMEOUT_CYCLES`, 16: max cycles in REQ without `ram_ack` before bus error; 0 disables timeout.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request strobe; sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-justified.
- `mask` in 2: 2'b00 byte, 2'b01 half, 2'b1x word (same encoding as `RamLoadProc`).
- `signed_ext` in 1: load sign-extension request, passed through.
- `busy` out 1: high in any state but IDLE.
- `done` out 1: one-cycle pulse on successful completion.
- `align_err` out 1: one-cycle pulse, misaligned request.
- `bus_err` out 1: one-cycle pulse, handshake timeout.
- `ram_req` out 1, `ram_we` out 1, `ram_addr` out 32 (`{addr[31:2],2'b00}`), `ram_wdata` out 32, `ram_be` out 4: RAM request, all registered.
- `ram_ack` in 1, `ram_rdata` in 32: RAM completion and read data (valid with ack on loads).
- `ld_word` out 32, `ld_addr` out 2, `ld_mask` out 2, `ld_signed` out 1: registered load results to `RamLoadProc`.

## Operation
- States: IDLE, REQ, DONE, ERR.
- IDLE: on `start`: misaligned (half with `addr[0]`=1, word with `addr[1:0]`≠0) → ERR with `align_err` set; no RAM activity. Otherwise latch request, load `ram_*`, → REQ.
- REQ: `ram_req`=1, all `ram_*` held stable. On `ram_ack`: loads capture `ram_rdata`→`ld_word`, `addr[1:0]`→`ld_addr`, `mask`→`ld_mask`, `signed_ext`→`ld_signed`; → DONE. Stores update no `ld_*`.
- Timeout: counter clears on REQ entry, increments each REQ cycle without ack; at `TIMEOUT_CYCLES` → ERR with `bus_err`. Ack arriving on the same cycle the limit is reached wins (success).
- DONE: `done`=1, `ram_req`=0, → IDLE. ERR: error pulse high, → IDLE.
- Store lanes (little-endian, byte 0 = bits 7:0): byte → `ram_wdata`={4{wdata[7:0]}}, `ram_be`=4'b0001<<`addr[1:0]`; half → {2{wdata[15:0]}}, `ram_be`=`addr[1]`?4'b1100:4'b0011; word → `wdata`, 4'b1111. Loads: `ram_be`=4'b1111, `ram_wdata`=0.
- `start` while busy ignored (not queued). `ld_*` hold last load result until the next successful load.

## Timing
- Reset: state IDLE; `busy`,`done`,`align_err`,`bus_err`,`ram_req`,`ram_we`=0; `ram_addr`,`ram_wdata`,`ld_word`=0; `ram_be`,`ld_addr`,`ld_mask`=0; `ld_signed`=0; counter 0.
- `start` sampled at edge N → `ram_req`/`busy` high from N+1. Ack sampled at edge N+1 (zero-wait RAM) → `done` and valid `ld_*` during N+2; back in IDLE at N+3, new `start` accepted at edge N+3. Each wait cycle adds one.
- Misaligned: `align_err` and `busy` high during N+1, IDLE at N+2.
- Timeout: with no ack, `ram_req` high for exactly `TIMEOUT_CYCLES` cycles, then `bus_err` for one cycle.
- Reset mid-transaction: `ram_req` drops asynchronously; request abandoned, no `done`.

## Structure
- Package `mem_access_pkg`: state enum, mask constants `MASK_BYTE`=2'b00, `MASK_HALF`=2'b01, `MASK_WORD`=2'b10, alignment-check function.
- Sub-module `store_lane_align`: combinational `wdata`/`addr[1:0]`/`mask` → `ram_wdata`/`ram_be`; instanced once, output registered in IDLE.

## Test plan
- Load word, addr 0x100, ack on first REQ cycle, rdata 0xDEADBEEF → `ram_addr`=0x100, `done` at N+2, `ld_word`=0xDEADBEEF, `ld_mask`=2'b10.
- Store byte 0xA5 to addr 0x203 → `ram_addr`=0x200, `ram_be`=4'b1000, `ram_wdata`=0xA5A5A5A5, `ram_we`=1; `ld_*` unchanged.
- Store half 0x1234 to 0x002, ack after 3 wait cycles → `ram_be`=4'b1100, `ram_wdata`=0x12341234, `ram_req` high 4 cycles, `done` once.
- Load half at 0x001 → `align_err` at N+1, `ram_req` never asserts; load word 0x006 likewise.
- TIMEOUT_CYCLES=16, ack never → `ram_req` high 16 cycles, `bus_err` pulse, IDLE; second `start` during wait ignored.
- Deassert `rst_n` mid-REQ → `ram_req`,`busy` low immediately; after release, clean load completes normally.
